// File: rtl/fetch_pc_predictor.sv
// IF-stage PC with a direct-mapped BTB and 2-bit counters.
// Define PRED_PERF_CNT_EN to add branch/mispredict perf counters.
`ifndef IM_ADDR_BIT
`define IM_ADDR_BIT 12
`endif

module fetch_pc_predictor #(
  parameter int ADDR_W = `IM_ADDR_BIT,
  parameter int IDX_W = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_4,
  output logic              gussed,
  input  logic              upd_en,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              ex_taken,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_gussed,
  output logic              flush_n
`ifdef PRED_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [TAG_W-1:0]  tag_d [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_d [ENTRIES];
  logic [1:0]        ctr_q [ENTRIES];
  logic [1:0]        ctr_d [ENTRIES];

  logic [IDX_W-1:0]  idx, eidx;
  logic              hit, ehit, mispredict;
  logic [ADDR_W-1:0] redirect_pc;

  always_comb begin
    idx = pc_q[IDX_W-1:0];
    eidx = ex_pc[IDX_W-1:0];
    hit = valid_q[idx] && (tag_q[idx] == pc_q[ADDR_W-1:IDX_W]);
    ehit = valid_q[eidx] && (tag_q[eidx] == ex_pc[ADDR_W-1:IDX_W]);
    mispredict = upd_en &&
      ((ex_taken != ex_gussed) ||
       (ex_taken && ex_gussed && ehit && (tgt_q[eidx] != ex_target)));
    redirect_pc = ex_taken ? ex_target : ex_pc + ADDR_W'(1);
  end

  assign pc      = pc_q;
  assign pc_4    = pc_q + ADDR_W'(1);
  assign gussed  = hit & ctr_q[idx][1];
  assign flush_n = ~mispredict;

  always_comb begin
    pc_d = pc_q;
    valid_d = valid_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    ctr_d = ctr_q;
    if (en) begin
      // a redirect must win over stall or the wrong path keeps fetching
      if (mispredict)  pc_d = redirect_pc;
      else if (stall)  pc_d = pc_q;
      else if (gussed) pc_d = tgt_q[idx];
      else             pc_d = pc_q + ADDR_W'(1);
      if (upd_en) begin
        if (ehit) begin
          if (ex_taken) begin
            if (ctr_q[eidx] != 2'b11) ctr_d[eidx] = ctr_q[eidx] + 2'd1;
            tgt_d[eidx] = ex_target;
          end else if (ctr_q[eidx] != 2'b00) begin
            ctr_d[eidx] = ctr_q[eidx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_d[eidx] = 1'b1;
          tag_d[eidx] = ex_pc[ADDR_W-1:IDX_W];
          tgt_d[eidx] = ex_target;
          ctr_d[eidx] = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= 2'b00;
      end
    end else begin
      pc_q <= pc_d;
      valid_q <= valid_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      ctr_q <= ctr_d;
    end
  end

`ifdef PRED_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (en && upd_en) br_cnt_d = br_cnt_q + 32'd1;
    if (en && mispredict) mp_cnt_d = mp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign perf_branches = br_cnt_q;
  assign perf_mispred = mp_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed scenarios plus random
// traffic checked every cycle against a table-level model.
module tb_fetch_pc_predictor;

  logic       clk = 1'b0;
  logic       rst_n, en, stall, upd_en;
  logic       ex_taken, ex_gussed;
  logic [7:0] ex_pc, ex_target;
  logic [7:0] pc, pc_4;
  logic       gussed, flush_n;
`ifdef PRED_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispred;
`endif

  always #5 clk = ~clk;

  fetch_pc_predictor #(.ADDR_W(8), .IDX_W(4), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
    .pc(pc), .pc_4(pc_4), .gussed(gussed),
    .upd_en(upd_en), .ex_pc(ex_pc), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_gussed(ex_gussed), .flush_n(flush_n)
`ifdef PRED_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
  );

  int compared = 0;
  int mismatched = 0;

  bit          mv [16];
  int          mtag [16];
  int          mtgt [16];
  int          mctr [16];
  int          mpc;
  bit          known = 0;
  int unsigned mbr, mmis;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(int a);
    return mv[a % 16] && (mtag[a % 16] == a / 16);
  endfunction

  task automatic drv(bit r, bit e, bit s, bit u, int p, bit t, int tg, bit g);
    rst_n = r; en = e; stall = s; upd_en = u;
    ex_pc = 8'(p); ex_taken = t; ex_target = 8'(tg); ex_gussed = g;
  endtask

  task automatic tick();
    bit g, mis;
    int ep, ei;
    @(negedge clk);
    ep = int'(ex_pc);
    ei = ep % 16;
    g = m_hit(mpc) && (mctr[mpc % 16] >= 2);
    mis = upd_en && ((ex_taken != ex_gussed) ||
          (ex_taken && ex_gussed && m_hit(ep) && (mtgt[ei] != int'(ex_target))));
    if (known) begin
      chk("pc", 32'(pc), 32'(mpc));
      chk("pc_4", 32'(pc_4), 32'((mpc + 1) % 256));
      chk("gussed", 32'(gussed), 32'(g));
      chk("flush_n", 32'(flush_n), 32'(!mis));
`ifdef PRED_PERF_CNT_EN
      chk("perf_branches", perf_branches, mbr);
      chk("perf_mispred", perf_mispred, mmis);
`endif
    end
    if (!rst_n) begin
      known = 1;
      mpc = 0; mbr = 0; mmis = 0;
      for (int i = 0; i < 16; i++) begin
        mv[i] = 0; mctr[i] = 0; mtag[i] = 0; mtgt[i] = 0;
      end
    end else if (en && known) begin
      if (upd_en) mbr++;
      if (mis) mmis++;
      if (mis) mpc = ex_taken ? int'(ex_target) : (ep + 1) % 256;
      else if (stall) mpc = mpc;
      else if (g) mpc = mtgt[mpc % 16];
      else mpc = (mpc + 1) % 256;
      if (upd_en) begin
        if (m_hit(ep)) begin
          if (ex_taken) begin
            mctr[ei] = (mctr[ei] == 3) ? 3 : mctr[ei] + 1;
            mtgt[ei] = int'(ex_target);
          end else begin
            mctr[ei] = (mctr[ei] == 0) ? 0 : mctr[ei] - 1;
          end
        end else if (ex_taken) begin
          mv[ei] = 1; mtag[ei] = ep / 16; mtgt[ei] = int'(ex_target); mctr[ei] = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_pc_4", 32'(pc_4), 32'h1);
    chk("rst_gussed", 32'(gussed), 32'h0);
    chk("rst_flush_n", 32'(flush_n), 32'h1);
    repeat (3) tick();
    chk("seq_pc", 32'(pc), 32'h3);
    drv(1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    chk("stall_pc", 32'(pc), 32'h3);

    drv(1, 1, 0, 1, 5, 1, 8'h20, 0);
    #1;
    chk("learn_flush", 32'(flush_n), 32'h0);
    tick();
    chk("learn_pc", 32'(pc), 32'h20);
    drv(1, 1, 0, 1, 4, 0, 0, 1);
    tick();
    chk("goto5_pc", 32'(pc), 32'h5);
    idle();
    chk("learn_guess", 32'(gussed), 32'h1);
    tick();
    chk("pred_pc", 32'(pc), 32'h20);

    drv(1, 1, 0, 1, 5, 0, 0, 1);
    tick();
    drv(1, 1, 0, 1, 5, 0, 0, 0);
    #1;
    chk("sat_flush1", 32'(flush_n), 32'h1);
    tick();
    drv(1, 1, 0, 1, 5, 0, 0, 0);
    #1;
    chk("sat_flush2", 32'(flush_n), 32'h1);
    tick();
    drv(1, 1, 0, 1, 4, 0, 0, 1);
    tick();
    idle();
    chk("sat_pc", 32'(pc), 32'h5);
    chk("sat_guess", 32'(gussed), 32'h0);

    drv(1, 1, 1, 1, 7, 0, 0, 1);
    tick();
    chk("prio_pc", 32'(pc), 32'h8);

    repeat (3) begin
      drv(1, 1, 0, 1, 5, 1, 8'h20, 1);
      tick();
    end
    drv(1, 1, 0, 1, 20, 0, 0, 1);
    tick();
    idle();
    chk("alias_pc", 32'(pc), 32'd21);
    chk("alias_guess", 32'(gussed), 32'h0);
    drv(1, 1, 0, 1, 4, 0, 0, 1);
    tick();
    idle();
    chk("hit_guess", 32'(gussed), 32'h1);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drv(1, 1, 0, 1, 4, 0, 0, 1);
    tick();
    idle();
    chk("post_rst_pc", 32'(pc), 32'h5);
    chk("post_rst_guess", 32'(gussed), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      int p, tg;
      p = 16 * $urandom_range(0, 2) + $urandom_range(0, 5);
      case ($urandom_range(0, 2))
        0: tg = 8'h20;
        1: tg = 8'h40;
        default: tg = $urandom_range(0, 255);
      endcase
      drv($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 4,
          p, $urandom_range(0, 1) == 1, tg, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
